// File: rtl/reduce_pkg.sv
// Shared types and constants for pseudo-Mersenne reduction.
// Defaults describe the Poly1305 field, P = 2^130 - 5.
package reduce_pkg;

   localparam int POLY1305_BITS = 130;
   localparam int POLY1305_C    = 5;
   localparam int PM_MAX_BITS   = 512;

   typedef enum logic [1:0] {
      IDLE,
      FOLD,
      FINAL,
      DONE
   } state_e;

   function automatic logic [PM_MAX_BITS-1:0] pm_modulus(
      input int n,
      input int c
   );
      logic [PM_MAX_BITS-1:0] one;
      one = PM_MAX_BITS'(1);
      return (one << n) - PM_MAX_BITS'(c);
   endfunction

endpackage

// File: rtl/pm_fold_unit.sv
// One combinational fold: x -> hi*C + lo, with a flag that hi is zero.
// With hi == 0 the fold is an identity.
module pm_fold_unit #(
   parameter int WORK_BITS = 259,
   parameter int MOD_BITS  = 130,
   parameter int MOD_C     = 5,
   parameter int C_BITS    = 3
) (
   input  logic [WORK_BITS-1:0] work_i,
   output logic [WORK_BITS-1:0] fold_o,
   output logic                 hi_zero_o
);

   localparam int HI_BITS = WORK_BITS - MOD_BITS;

   logic [HI_BITS-1:0]  hi;
   logic [MOD_BITS-1:0] lo;
   logic [C_BITS-1:0]   c;

   assign hi = work_i[WORK_BITS-1:MOD_BITS];
   assign lo = work_i[MOD_BITS-1:0];
   assign c  = C_BITS'(MOD_C);

   assign fold_o = ({{MOD_BITS{1'b0}}, hi}
                    * {{(WORK_BITS-C_BITS){1'b0}}, c})
                   + {{HI_BITS{1'b0}}, lo};

   assign hi_zero_o = (hi == '0);

endmodule

// File: rtl/reduce_mod_pseudo_mersenne.sv
// Streaming x mod (2^MOD_BITS - MOD_C) by iterative folding.
// Define REDUCE_CONST_TIME_EN for a fixed MAX_FOLDS fold count.
module reduce_mod_pseudo_mersenne
   import reduce_pkg::*;
#(
   parameter int IN_BITS   = 258,
   parameter int MOD_BITS  = POLY1305_BITS,
   parameter int MOD_C     = POLY1305_C,
   parameter int C_BITS    = 3,
   parameter int MAX_FOLDS = 3,
   parameter int TAG_BITS  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_BITS-1:0]  in_data,
   input  logic [TAG_BITS-1:0] in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [MOD_BITS-1:0] out_data,
   output logic [TAG_BITS-1:0] out_tag,
   output logic                out_err,
   output logic                busy
);

   localparam int WORK_BITS = IN_BITS + 1;
   localparam int CNT_BITS  = $clog2(MAX_FOLDS + 1);
   localparam logic [WORK_BITS-1:0] P =
      WORK_BITS'(pm_modulus(MOD_BITS, MOD_C));
   localparam logic [CNT_BITS-1:0] LAST_CNT =
      CNT_BITS'(MAX_FOLDS - 1);

   state_e              state_q, state_d;
   logic [WORK_BITS-1:0] work_q, work_d;
   logic [CNT_BITS-1:0]  fold_cnt_q, fold_cnt_d;
   logic [TAG_BITS-1:0]  tag_q, tag_d;
   logic [MOD_BITS-1:0]  out_data_q, out_data_d;
   logic [TAG_BITS-1:0]  out_tag_q, out_tag_d;
   logic                 out_err_q, out_err_d;
   logic                 out_valid_q, out_valid_d;

   logic [WORK_BITS-1:0] fold;
   logic                 hi_zero;
   logic                 last_fold;

   pm_fold_unit #(
      .WORK_BITS (WORK_BITS),
      .MOD_BITS  (MOD_BITS),
      .MOD_C     (MOD_C),
      .C_BITS    (C_BITS)
   ) u_fold (
      .work_i    (work_q),
      .fold_o    (fold),
      .hi_zero_o (hi_zero)
   );

`ifdef REDUCE_CONST_TIME_EN
   assign last_fold = (fold_cnt_q == LAST_CNT) | (hi_zero & 1'b0);
`else
   assign last_fold = (fold_cnt_q == LAST_CNT) | hi_zero;
`endif

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      fold_cnt_d  = fold_cnt_q;
      tag_d       = tag_q;
      out_data_d  = out_data_q;
      out_tag_d   = out_tag_q;
      out_err_d   = out_err_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d     = {1'b0, in_data};
               tag_d      = in_tag;
               fold_cnt_d = '0;
               state_d    = FOLD;
            end
         end
         FOLD: begin
            work_d     = fold;
            fold_cnt_d = fold_cnt_q + CNT_BITS'(1);
            if (last_fold) state_d = FINAL;
         end
         FINAL: begin
            out_err_d   = |work_q[WORK_BITS-1:MOD_BITS];
            out_data_d  = MOD_BITS'((work_q >= P) ? work_q - P : work_q);
            out_tag_d   = tag_q;
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            // out_data deliberately keeps its last value
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_err_d   = 1'b0;
               state_d     = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         work_q      <= '0;
         fold_cnt_q  <= '0;
         tag_q       <= '0;
         out_data_q  <= '0;
         out_tag_q   <= '0;
         out_err_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         fold_cnt_q  <= fold_cnt_d;
         tag_q       <= tag_d;
         out_data_q  <= out_data_d;
         out_tag_q   <= out_tag_d;
         out_err_q   <= out_err_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_tag   = out_tag_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_reduce_mod_pseudo_mersenne.sv
// Bench for reduce_mod_pseudo_mersenne: vector table, random model
// checks, backpressure, mid-operation reset and a MAX_FOLDS=1 instance.
module tb_reduce_mod_pseudo_mersenne;

   localparam int IN_BITS  = 258;
   localparam int MOD_BITS = 130;
   localparam int TAG_BITS = 4;
   localparam int MAXF     = 3;
   localparam logic [259:0] P  = (260'd1 << 130) - 260'd5;
   localparam logic [259:0] R2 = 260'd1 << 130;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic                in_valid, in_ready, out_valid, out_ready;
   logic [IN_BITS-1:0]  in_data;
   logic [TAG_BITS-1:0] in_tag, out_tag;
   logic [MOD_BITS-1:0] out_data;
   logic                out_err, busy;

   logic                in_valid1, in_ready1, out_valid1, out_ready1;
   logic [IN_BITS-1:0]  in_data1;
   logic [TAG_BITS-1:0] in_tag1, out_tag1;
   logic [MOD_BITS-1:0] out_data1;
   logic                out_err1, busy1;

   reduce_mod_pseudo_mersenne dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag),
      .out_err(out_err), .busy(busy)
   );

   reduce_mod_pseudo_mersenne #(.MAX_FOLDS(1)) dut1 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .in_data(in_data1), .in_tag(in_tag1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_data(out_data1), .out_tag(out_tag1),
      .out_err(out_err1), .busy(busy1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [259:0] act,
                      input logic [259:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: residue by plain modulo, fold count from the fold rule.
   task automatic model(input logic [257:0] d, input int maxf,
                        output logic [129:0] q, output logic e,
                        output int lat);
      logic [259:0] x, hi;
      int f;
      x = {2'b0, d};
      f = 0;
      do begin
         hi = x / R2;
         x  = hi * 260'd5 + (x % R2);
         f++;
      end while (hi != 0 && f < maxf);
      e = (x >= R2);
      q = 130'(({2'b0, d}) % P);
`ifdef REDUCE_CONST_TIME_EN
      lat = maxf + 1;
`else
      lat = f + 1;
`endif
   endtask

   task automatic do_req(input logic [257:0] d, input logic [3:0] t,
                         output logic [129:0] rd, output logic [3:0] rt,
                         output logic re, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      chk("in_ready_idle", in_ready, 1);
      in_valid = 1; in_data = d; in_tag = t;
      @(posedge clk); #1;
      in_valid = 0; in_data = '0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      rd = out_data; rt = out_tag; re = out_err;
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("out_valid_drop", out_valid, 0);
   endtask

   typedef struct {
      logic [257:0] din;
      logic [3:0]   tag;
      logic [129:0] dout;
      int           lat;
   } vec_t;

   vec_t tbl[7];

   initial begin
      logic [129:0] rd, eq;
      logic [3:0]   rt;
      logic         re, ee;
      int           lat, el, w;
      logic [257:0] r, a, b;

      tbl[0] = '{258'd0, 4'd3, 130'd0, 2};
      tbl[1] = '{258'(P), 4'd1, 130'd0, 2};
      tbl[2] = '{258'(P - 1), 4'd2, 130'(P - 1), 2};
      tbl[3] = '{258'(R2 - 1), 4'd4, 130'd4, 2};
      tbl[4] = '{{258{1'b1}}, 4'd15,
                 130'h1_0000_0000_0000_0000_0000_0000_0000_0004, 4};
      tbl[5] = '{258'd7, 4'd8, 130'd7, 2};
      tbl[6] = '{258'(R2), 4'd9, 130'd5, 3};
`ifdef REDUCE_CONST_TIME_EN
      foreach (tbl[i]) tbl[i].lat = MAXF + 1;
`endif

      reset = 1;
      in_valid = 0; in_data = '0; in_tag = '0; out_ready = 0;
      in_valid1 = 0; in_data1 = '0; in_tag1 = '0; out_ready1 = 0;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk); reset = 0;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         do_req(tbl[i].din, tbl[i].tag, rd, rt, re, lat);
         chk($sformatf("tbl%0d_data", i), rd, tbl[i].dout);
         chk($sformatf("tbl%0d_tag", i), rt, tbl[i].tag);
         chk($sformatf("tbl%0d_err", i), re, 0);
         chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      end

      for (int i = 0; i < 40; i++) begin
         r = '0;
         for (int k = 0; k < 9; k++) r = (r << 32) | 258'($urandom());
         r = r >> $urandom_range(0, 257);
         model(r, MAXF, eq, ee, el);
         do_req(r, 4'($urandom()), rd, rt, re, lat);
         chk($sformatf("rnd%0d_data", i), rd, eq);
         chk($sformatf("rnd%0d_err", i), re, ee);
         chk($sformatf("rnd%0d_lat", i), lat, el);
      end

      // Backpressure with a held follow-up request
      a = {258{1'b1}} >> 3;
      b = 258'(P + 11);
      in_valid = 1; in_data = a; in_tag = 4'd5;
      @(posedge clk); #1;
      in_data = b; in_tag = 4'd6;
      w = 0;
      while (!out_valid && w < 20) begin
         @(posedge clk); #1; w++;
      end
      model(a, MAXF, eq, ee, el);
      chk("bp_data", out_data, eq);
      chk("bp_tag", out_tag, 5);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_data", out_data, eq);
         chk("bp_hold_tag", out_tag, 5);
         chk("bp_hold_in_ready", in_ready, 0);
      end
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("bp_bubble_valid", out_valid, 0);
      chk("bp_bubble_busy", busy, 0);
      chk("bp_bubble_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 0;
      chk("bp_accept_busy", busy, 1);
      w = 0;
      while (!out_valid && w < 20) begin
         @(posedge clk); #1; w++;
      end
      chk("bp2_data", out_data, 11);
      chk("bp2_tag", out_tag, 6);
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;

      // Reset during FOLD
      in_valid = 1; in_data = {258{1'b1}}; in_tag = 4'd2;
      @(posedge clk); #1;
      in_valid = 0;
      @(posedge clk); #1;
      reset = 1;
      #1;
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_data", out_data, 0);
      chk("rst_mid_tag", out_tag, 0);
      chk("rst_mid_err", out_err, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_in_ready", in_ready, 1);
      @(posedge clk); #2;
      reset = 0;
      @(posedge clk); #1;
      do_req(258'd7, 4'd9, rd, rt, re, lat);
      chk("post_rst_data", rd, 7);
      chk("post_rst_tag", rt, 9);
      chk("post_rst_lat", lat, MAXF > 0 ? 2 : 0);

      // Single-fold instance flags the bound overflow
      in_valid1 = 1; in_data1 = {258{1'b1}}; in_tag1 = 4'd12;
      @(posedge clk); #1;
      in_valid1 = 0;
      lat = 0;
      while (!out_valid1 && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      chk("mf1_err", out_err1, 1);
      chk("mf1_tag", out_tag1, 12);
      chk("mf1_lat", lat, 2);
      out_ready1 = 1;
      @(posedge clk); #1;
      out_ready1 = 0;
      chk("mf1_err_clear", out_err1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
